// File: rtl/ula_pkg.sv
// rtl/ula_pkg.sv - operation encodings shared by the ula_rv64i execute-stage ALU
package ula_pkg;

    localparam logic [2:0] ULA_ADD  = 3'b000;
    localparam logic [2:0] ULA_SLL  = 3'b001;
    localparam logic [2:0] ULA_SLT  = 3'b010;
    localparam logic [2:0] ULA_SLTU = 3'b011;
    localparam logic [2:0] ULA_XOR  = 3'b100;
    localparam logic [2:0] ULA_SR   = 3'b101;
    localparam logic [2:0] ULA_OR   = 3'b110;
    localparam logic [2:0] ULA_AND  = 3'b111;

endpackage

// File: rtl/ula_adder.sv
// rtl/ula_adder.sv - combinational add/sub with zero/negative/carry/overflow status
module ula_adder #(
    parameter int W = 64
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         sub_eff,
    output logic [W-1:0] s,
    output logic         c,
    output logic         zero,
    output logic         negative,
    output logic         overflow
);

    logic [W-1:0] b_eff;

    // Subtraction is A + ~B + 1; the carry out then means "no borrow".
    always_comb begin
        b_eff    = sub_eff ? ~b : b;
        {c, s}   = {1'b0, a} + {1'b0, b_eff} + {{W{1'b0}}, sub_eff};
        zero     = (s == '0);
        negative = s[W-1];
        overflow = ~(a[W-1] ^ b[W-1] ^ sub_eff) & (a[W-1] ^ s[W-1]);
    end

endmodule

// File: rtl/ula_rv64i.sv
// rtl/ula_rv64i.sv - registered RV64I integer ALU; optional ULA_WORD_OP_EN adds the 32-bit word ops
module ula_rv64i
    import ula_pkg::*;
#(
    parameter int N = 64
) (
    input  logic         clock,
    input  logic         reset,
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    input  logic [2:0]   seletor,
    input  logic         sub,
    input  logic         arithmetic,
`ifdef ULA_WORD_OP_EN
    input  logic         word,
`endif
    output logic [N-1:0] Y,
    output logic         zero,
    output logic         negative,
    output logic         carry_out,
    output logic         overflow
);

    localparam int SH_W = $clog2(N);

    logic         sub_eff;
    logic [N-1:0] s;
    logic         c;
    logic         f_zero;
    logic         f_neg;
    logic         f_ovf;
    logic [N-1:0] y_next;
    logic         zero_next;
    logic         neg_next;
    logic         carry_next;
    logic         ovf_next;

    // SLT/SLTU always need a subtraction regardless of the sub input.
    assign sub_eff = sub | (~seletor[2] & seletor[1]);

    ula_adder #(.W(N)) u_adder (
        .a        (A),
        .b        (B),
        .sub_eff  (sub_eff),
        .s        (s),
        .c        (c),
        .zero     (f_zero),
        .negative (f_neg),
        .overflow (f_ovf)
    );

`ifdef ULA_WORD_OP_EN
    logic [31:0] s_w;
    logic        c_w;
    logic        zero_w;
    logic        neg_w;
    logic        ovf_w;
    logic [31:0] r_w;

    ula_adder #(.W(32)) u_adder_w (
        .a        (A[31:0]),
        .b        (B[31:0]),
        .sub_eff  (sub_eff),
        .s        (s_w),
        .c        (c_w),
        .zero     (zero_w),
        .negative (neg_w),
        .overflow (ovf_w)
    );

    // Word-mode result on the low 32 bits; shift amount is B[4:0], SRA fills from bit 31.
    always_comb begin
        r_w = '0;
        unique case (seletor)
            ULA_ADD:  r_w = s_w;
            ULA_SLL:  r_w = A[31:0] << B[4:0];
            ULA_SLT:  r_w = {31'd0, neg_w ^ ovf_w};
            ULA_SLTU: r_w = {31'd0, ~c_w};
            ULA_XOR:  r_w = A[31:0] ^ B[31:0];
            ULA_SR:   r_w = arithmetic ? 32'($signed(A[31:0]) >>> B[4:0])
                                       : A[31:0] >> B[4:0];
            ULA_OR:   r_w = A[31:0] | B[31:0];
            ULA_AND:  r_w = A[31:0] & B[31:0];
            default:  r_w = '0;
        endcase
    end
`endif

    logic [SH_W-1:0] sh;
    logic [N-1:0]    r_full;

    assign sh = B[SH_W-1:0];

    // Full-width result select; flags always come from the adder.
    always_comb begin
        r_full = '0;
        unique case (seletor)
            ULA_ADD:  r_full = s;
            ULA_SLL:  r_full = A << sh;
            ULA_SLT:  r_full = {{(N-1){1'b0}}, f_neg ^ f_ovf};
            ULA_SLTU: r_full = {{(N-1){1'b0}}, ~c};
            ULA_XOR:  r_full = A ^ B;
            ULA_SR:   r_full = arithmetic ? N'($signed(A) >>> sh) : A >> sh;
            ULA_OR:   r_full = A | B;
            ULA_AND:  r_full = A & B;
            default:  r_full = '0;
        endcase
    end

    // Choose between the full-width and word-mode paths.
    always_comb begin
        y_next     = r_full;
        zero_next  = f_zero;
        neg_next   = f_neg;
        carry_next = c;
        ovf_next   = f_ovf;
`ifdef ULA_WORD_OP_EN
        if (word) begin
            y_next     = {{(N-32){r_w[31]}}, r_w};
            zero_next  = zero_w;
            neg_next   = neg_w;
            carry_next = c_w;
            ovf_next   = ovf_w;
        end
`endif
    end

    // Output registers: one cycle of latency, cleared asynchronously by reset.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            Y         <= '0;
            zero      <= 1'b0;
            negative  <= 1'b0;
            carry_out <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            Y         <= y_next;
            zero      <= zero_next;
            negative  <= neg_next;
            carry_out <= carry_next;
            overflow  <= ovf_next;
        end
    end

endmodule

// File: tb/tb_ula_rv64i.sv
// tb/tb_ula_rv64i.sv - table-driven self-checking bench for ula_rv64i at N=8
module tb_ula_rv64i;

    localparam int N = 8;

    logic         clock;
    logic         reset;
    logic [N-1:0] A;
    logic [N-1:0] B;
    logic [2:0]   seletor;
    logic         sub;
    logic         arithmetic;
`ifdef ULA_WORD_OP_EN
    logic         word;
`endif
    logic [N-1:0] Y;
    logic         zero;
    logic         negative;
    logic         carry_out;
    logic         overflow;

    ula_rv64i #(.N(N)) dut (
        .clock      (clock),
        .reset      (reset),
        .A          (A),
        .B          (B),
        .seletor    (seletor),
        .sub        (sub),
        .arithmetic (arithmetic),
`ifdef ULA_WORD_OP_EN
        .word       (word),
`endif
        .Y          (Y),
        .zero       (zero),
        .negative   (negative),
        .carry_out  (carry_out),
        .overflow   (overflow)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        string        name;
        logic [N-1:0] a;
        logic [N-1:0] b;
        logic [2:0]   sel;
        logic         sb;
        logic         ar;
        logic [N-1:0] y;
        logic [3:0]   flags;   // {zero, negative, carry_out, overflow}
    } vec_t;

    vec_t vecs[$];
    int   n_applied;
    int   n_fail;

    task automatic check(input string name, input logic [N+3:0] got, input logic [N+3:0] exp);
        n_applied++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got Y=%02h zncv=%04b, want Y=%02h zncv=%04b",
                     name, got[N+3:4], got[3:0], exp[N+3:4], exp[3:0]);
        end
    endtask

    function automatic logic [N+3:0] outs();
        return {Y, zero, negative, carry_out, overflow};
    endfunction

    task automatic drive(input logic [N-1:0] a, input logic [N-1:0] b,
                         input logic [2:0] sel, input logic sb, input logic ar);
        A = a; B = b; seletor = sel; sub = sb; arithmetic = ar;
    endtask

    initial begin
        vecs.push_back('{"add",        8'h28, 8'h85, 3'b000, 1'b0, 1'b0, 8'hAD, 4'b0100});
        vecs.push_back('{"sub",        8'h28, 8'h85, 3'b000, 1'b1, 1'b0, 8'hA3, 4'b0101});
        vecs.push_back('{"slt_false",  8'h28, 8'h85, 3'b010, 1'b0, 1'b0, 8'h00, 4'b0101});
        vecs.push_back('{"sltu_true",  8'h28, 8'h85, 3'b011, 1'b0, 1'b0, 8'h01, 4'b0101});
        vecs.push_back('{"slt_true",   8'h85, 8'h28, 3'b010, 1'b0, 1'b0, 8'h01, 4'b0011});
        vecs.push_back('{"sltu_false", 8'h85, 8'h28, 3'b011, 1'b0, 1'b0, 8'h00, 4'b0011});
        vecs.push_back('{"sll",        8'hF0, 8'h2A, 3'b001, 1'b0, 1'b0, 8'hC0, 4'b0010});
        vecs.push_back('{"srl",        8'hF0, 8'h2A, 3'b101, 1'b0, 1'b0, 8'h3C, 4'b0010});
        vecs.push_back('{"sra",        8'hF0, 8'h2A, 3'b101, 1'b0, 1'b1, 8'hFC, 4'b0010});
        vecs.push_back('{"sra_by7",    8'h80, 8'h07, 3'b101, 1'b0, 1'b1, 8'hFF, 4'b0100});
        vecs.push_back('{"sll_by7",    8'h01, 8'h07, 3'b001, 1'b0, 1'b1, 8'h80, 4'b0000});
        vecs.push_back('{"xor",        8'h50, 8'hA6, 3'b100, 1'b0, 1'b0, 8'hF6, 4'b0100});
        vecs.push_back('{"or",         8'h50, 8'hA6, 3'b110, 1'b0, 1'b0, 8'hF6, 4'b0100});
        vecs.push_back('{"and",        8'h50, 8'hA6, 3'b111, 1'b0, 1'b0, 8'h00, 4'b0100});
        vecs.push_back('{"sub_equal",  8'h64, 8'h64, 3'b000, 1'b1, 1'b0, 8'h00, 4'b1010});
        vecs.push_back('{"add_ovf",    8'h7F, 8'h01, 3'b000, 1'b0, 1'b0, 8'h80, 4'b0101});
        vecs.push_back('{"add_carry",  8'hFF, 8'h01, 3'b000, 1'b0, 1'b0, 8'h00, 4'b1010});

        n_applied = 0;
        n_fail    = 0;
`ifdef ULA_WORD_OP_EN
        word = 1'b0;
`endif
        reset = 1'b1;
        drive(8'h28, 8'h85, 3'b000, 1'b0, 1'b0);
        #3;
        check("reset_state", outs(), {8'h00, 4'b0000});
        @(posedge clock);
        #1;
        check("reset_held_edge", outs(), {8'h00, 4'b0000});
        @(negedge clock);
        reset = 1'b0;

        // Back-to-back operations, one per cycle.
        foreach (vecs[i]) begin
            @(negedge clock);
            drive(vecs[i].a, vecs[i].b, vecs[i].sel, vecs[i].sb, vecs[i].ar);
            @(posedge clock);
            #1;
            check(vecs[i].name, outs(), {vecs[i].y, vecs[i].flags});
        end

        // Asynchronous reset mid-cycle with a nonzero result in the register.
        @(negedge clock);
        drive(8'h28, 8'h85, 3'b000, 1'b0, 1'b0);
        @(posedge clock);
        #1;
        check("pre_reset_add", outs(), {8'hAD, 4'b0100});
        #2;
        reset = 1'b1;
        #1;
        check("reset_async", outs(), {8'h00, 4'b0000});
        repeat (2) @(posedge clock);
        #1;
        check("reset_holds", outs(), {8'h00, 4'b0000});
        @(negedge clock);
        reset = 1'b0;
        drive(8'h28, 8'h85, 3'b000, 1'b1, 1'b0);
        #1;
        check("after_release_no_edge", outs(), {8'h00, 4'b0000});
        @(posedge clock);
        #1;
        check("first_edge_after_reset", outs(), {8'hA3, 4'b0101});

        $display("== %0d vectors applied, %0d miscompares ==", n_applied, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
